// File: rtl/nios2_secure_memory_cpu_mul_seq.sv
// nios2_secure_memory_cpu_mul_seq: two-pass sequencer around the 16x16 three-product multiplier cell,
// assembling the 64-bit product for MUL / MULXUU / MULXSS / MULXSU.
module nios2_secure_memory_cpu_mul_seq #(
   parameter int CELL_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        flush,
   input  logic [1:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3
);
   typedef enum logic [2:0] {IDLE, P1, WAIT1, P2, WAIT2, ACC, FIX, OUT} state_t;
   localparam logic [1:0] WN = 2'(CELL_LATENCY - 1);
   state_t state;
   logic [1:0] wcnt, op_q;
   logic [31:0] a, b, res_q, corr, res_new;
   logic [63:0] acc;
   logic [32:0] mid;
   logic go_p2, go_acc;
   assign go_p2 = (state == P1 && WN == 2'd0) || (state == WAIT1 && wcnt == WN);
   assign go_acc = (state == P2 && WN == 2'd0) || (state == WAIT2 && wcnt == WN);
   assign mid = {1'b0, cell_p2} + {1'b0, cell_p3};
   // Two's-complement fix-up of the unsigned high word for signed operands
   assign corr = ((op_q[1] && a[31]) ? b : 32'h0) + ((op_q == 2'd2 && b[31]) ? a : 32'h0);
   assign res_new = (op_q == 2'd0) ? acc[31:0] : acc[63:32];
   assign busy = state != IDLE;
   // A flush in OUT suppresses the pulse and leaves the held result untouched
   assign done = state == OUT && !flush;
   assign result = done ? res_new : res_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         wcnt <= '0;
         op_q <= '0;
         a <= '0;
         b <= '0;
         acc <= '0;
         res_q <= '0;
         cell_src1 <= '0;
         cell_src2 <= '0;
         cell_en <= 1'b0;
      end else begin
         cell_en <= 1'b0;
         if (flush) state <= IDLE;
         else begin
            case (state)
               IDLE: if (start) begin
                  a <= src1;
                  b <= src2;
                  op_q <= op;
                  acc <= '0;
                  cell_src1 <= src1;
                  cell_src2 <= src2;
                  cell_en <= 1'b1;
                  state <= P1;
               end
               P1, WAIT1: begin
                  wcnt <= (state == P1) ? 2'd1 : wcnt + 2'd1;
                  if (go_p2) begin
                     cell_src1 <= {16'h0, a[31:16]};
                     cell_src2 <= {16'h0, b[31:16]};
                     cell_en <= 1'b1;
                  end
                  state <= go_p2 ? P2 : WAIT1;
               end
               P2: begin
                  acc <= {32'h0, cell_p1} + {15'h0, mid, 16'h0};
                  wcnt <= 2'd1;
                  state <= go_acc ? ACC : WAIT2;
               end
               WAIT2: begin
                  wcnt <= wcnt + 2'd1;
                  state <= go_acc ? ACC : WAIT2;
               end
               ACC: begin
                  acc[63:32] <= acc[63:32] + cell_p1;
                  state <= FIX;
               end
               FIX: begin
                  acc[63:32] <= acc[63:32] - corr;
                  state <= OUT;
               end
               OUT: begin
                  res_q <= res_new;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_nios2_secure_memory_cpu_mul_seq.sv
// tb_nios2_secure_memory_cpu_mul_seq: two sequencers (cell latency 1 and 2) with behavioural cells,
// checked every cycle against a transaction-level product model plus directed literal cases.
module tb_nios2_secure_memory_cpu_mul_seq;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic        start_s [2];
   logic        flush_s [2];
   logic [1:0]  op_s [2];
   logic [31:0] src1_s [2], src2_s [2];
   logic        busy_w [2], done_w [2], cell_en_w [2];
   logic [31:0] result_w [2], cs1_w [2], cs2_w [2], p1_w [2], p2_w [2], p3_w [2];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xa, ya, p;
      xa = (o[1]) ? {{32{x[31]}}, x} : {32'h0, x};
      ya = (o == 2'd2) ? {{32{y[31]}}, y} : {32'h0, y};
      p = xa * ya;
      return (o == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 3))
         0: return 32'hFFFF_FFFF - $urandom_range(0, 3);
         1: return 32'h8000_0000 | $urandom_range(0, 255);
         default: return $urandom;
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int L = g + 1;
      localparam int N = 5 + 2 * (L - 1);
      logic [31:0] s1 [3], s2 [3];
      int m_left = 0;
      logic [31:0] m_exp = '0, m_res = '0;
      logic e_done;

      nios2_secure_memory_cpu_mul_seq #(.CELL_LATENCY(L)) dut (
         .clk(clk), .reset_n(reset_n), .start(start_s[g]), .flush(flush_s[g]), .op(op_s[g]),
         .src1(src1_s[g]), .src2(src2_s[g]), .busy(busy_w[g]), .done(done_w[g]), .result(result_w[g]),
         .cell_src1(cs1_w[g]), .cell_src2(cs2_w[g]), .cell_en(cell_en_w[g]),
         .cell_p1(p1_w[g]), .cell_p2(p2_w[g]), .cell_p3(p3_w[g]));

      always @(posedge clk) begin
         if (cell_en_w[g]) begin
            s1[0] <= {16'h0, cs1_w[g][15:0]} * {16'h0, cs2_w[g][15:0]};
            s1[1] <= {16'h0, cs1_w[g][15:0]} * {16'h0, cs2_w[g][31:16]};
            s1[2] <= {16'h0, cs1_w[g][31:16]} * {16'h0, cs2_w[g][15:0]};
         end
         s2 <= s1;
      end
      assign p1_w[g] = (L == 1) ? s1[0] : s2[0];
      assign p2_w[g] = (L == 1) ? s1[1] : s2[1];
      assign p3_w[g] = (L == 1) ? s1[2] : s2[2];

      // Model: an accepted op is busy for N cycles, done in the last one unless flushed
      always @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            m_left <= 0;
            m_res <= '0;
            m_exp <= '0;
         end else if (m_left > 0) begin
            if (flush_s[g]) m_left <= 0;
            else begin
               if (m_left == 1) m_res <= m_exp;
               m_left <= m_left - 1;
            end
         end else if (start_s[g] && !flush_s[g]) begin
            m_left <= N;
            m_exp <= ref_mul(op_s[g], src1_s[g], src2_s[g]);
         end
      end
      assign e_done = m_left == 1 && !flush_s[g];

      always @(negedge clk) begin
         chk($sformatf("busy%0d", g), busy_w[g], m_left != 0);
         chk($sformatf("done%0d", g), done_w[g], e_done);
         chk($sformatf("result%0d", g), result_w[g], e_done ? m_exp : m_res);
         chk($sformatf("cell_en%0d", g), cell_en_w[g], m_left != 0 && (m_left == N || m_left == N - L));
      end
   end

   task automatic run_op(input int i, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int lat);
      int got, ens;
      got = 0;
      ens = 0;
      @(posedge clk);
      #1;
      start_s[i] = 1'b1;
      op_s[i] = o;
      src1_s[i] = x;
      src2_s[i] = y;
      @(posedge clk);
      #1;
      start_s[i] = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (cell_en_w[i]) ens++;
         if (done_w[i]) begin
            got = c;
            break;
         end
      end
      chk($sformatf("latency op%0d inst%0d", o, i), got, lat);
      chk($sformatf("dir_result op%0d %h*%h", o, x, y), result_w[i], exp);
      chk($sformatf("cell_en_pulses inst%0d", i), ens, 2);
   endtask

   initial begin
      int dn;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         flush_s[i] = 1'b0;
         op_s[i] = '0;
         src1_s[i] = '0;
         src2_s[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("reset_busy", busy_w[0], 1'b0);
      chk("reset_result", result_w[0], 32'h0);
      chk("reset_cell_src1", cs1_w[0], 32'h0);
      #1 reset_n = 1'b1;
      chk("model_xss", ref_mul(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0);
      chk("model_xsu", ref_mul(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

      run_op(0, 2'd0, 32'd3, 32'd5, 32'h0000_000F, 5);
      run_op(0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
      run_op(0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5);
      run_op(0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5);
      run_op(0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
      run_op(0, 2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 5);
      run_op(0, 2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 5);

      // start held high while busy, flush in ACC
      @(posedge clk);
      #1;
      start_s[0] = 1'b1;
      op_s[0] = 2'd1;
      src1_s[0] = 32'hFFFF_FFFF;
      src2_s[0] = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1 flush_s[0] = 1'b1;
      @(posedge clk);
      #1;
      flush_s[0] = 1'b0;
      start_s[0] = 1'b0;
      chk("flush_busy", busy_w[0], 1'b0);
      chk("flush_result", result_w[0], 32'h0000_0001);
      dn = 0;
      repeat (8) begin
         @(negedge clk);
         if (done_w[0]) dn++;
      end
      chk("flush_no_done", dn, 0);

      // async reset during P2
      @(posedge clk);
      #1;
      start_s[0] = 1'b1;
      op_s[0] = 2'd0;
      src1_s[0] = 32'd7;
      src2_s[0] = 32'd9;
      @(posedge clk);
      #1 start_s[0] = 1'b0;
      @(posedge clk);
      #1 chk("p2_cell_en", cell_en_w[0], 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_busy", busy_w[0], 1'b0);
      chk("arst_done", done_w[0], 1'b0);
      chk("arst_cell_en", cell_en_w[0], 1'b0);
      @(negedge clk);
      #1 reset_n = 1'b1;
      run_op(0, 2'd1, 32'd2, 32'd3, 32'h0000_0000, 5);
      run_op(0, 2'd0, 32'd2, 32'd3, 32'h0000_0006, 5);

      run_op(1, 2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 7);
      run_op(1, 2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 7);
      run_op(1, 2'd2, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 7);

      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            start_s[i] = $urandom_range(0, 3) == 0;
            flush_s[i] = $urandom_range(0, 19) == 0;
            op_s[i] = 2'($urandom);
            src1_s[i] = pick();
            src2_s[i] = pick();
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         flush_s[i] = 1'b0;
      end
      repeat (10) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/nios2_secure_memory_cpu_mul_seq.md
Name: nios2_secure_memory_cpu_mul_seq

Overview:
- Multi-cycle multiply sequencer wrapped around the 3-partial-product multiplier cell (16x16 products p1=lo*lo, p2=lo*hi, p3=hi*lo, registered, gated by the cell enable).
- Feeds the cell's operand/enable inputs and consumes its p1/p2/p3 outputs.
- Runs two cell passes and assembles the full 64-bit product, so one unit serves MUL, MULXUU, MULXSS and MULXSU.
- Sits between the execute-stage operand latch and the A-stage result mux.

Parameters:
CELL_LATENCY, 1, cycles from a cell_en=1 edge until p1..p3 are valid; legal values 1..2.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only in IDLE
flush  input  1  synchronous abort; returns to IDLE, no done
op  input  2  0=MUL(lo32), 1=MULXUU, 2=MULXSS, 3=MULXSU (rA signed, rB unsigned); all X-ops return hi32
src1  input  32  operand A (rA)
src2  input  32  operand B (rB)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, result valid
result  output  32  product word; holds until the next done
cell_src1  output  32  to cell E_src1
cell_src2  output  32  to cell E_src2
cell_en  output  1  to cell M_en
cell_p1  input  32  from cell, a_lo*b_lo
cell_p2  input  32  from cell, a_lo*b_hi
cell_p3  input  32  from cell, a_hi*b_lo

Behaviour:
- Interface: one clock clk; reset_n is asynchronous, active-low.
- Reset: state=IDLE; busy=0; done=0; result=0; cell_src1=cell_src2=0; cell_en=0; acc=0; wait counter=0; latched a/b/op=0.
- IDLE:
  - start=1 latches a=src1, b=src2, op, clears acc, and goes to P1.
  - start is ignored when not in IDLE; no queuing.
- P1:
  - cell_src1=a, cell_src2=b, cell_en=1 for exactly one cycle.
  - Then WAIT1 for CELL_LATENCY-1 cycles (zero cycles when CELL_LATENCY=1).
  - Then P2.
- P2:
  - Capture acc = p1 + ((p2 + p3) << 16), with p2+p3 computed at 33 bits and acc 64-bit unsigned.
  - Same cycle: cell_src1={16'h0,a[31:16]}, cell_src2={16'h0,b[31:16]}, cell_en=1.
  - Then WAIT2 (CELL_LATENCY-1 cycles), then ACC.
- ACC: acc[63:32] += p1 (a_hi*b_hi); modulo 2^32 on the high word. Then FIX.
- FIX (signed correction, modulo 2^32 on hi):
  - MULXSS: hi -= (a[31]?b:0) + (b[31]?a:0).
  - MULXSU: hi -= (a[31]?b:0).
  - MUL, MULXUU: no change.
  - Then OUT.
- OUT:
  - result <= (op==0) ? acc[31:0] : acc[63:32].
  - done=1 for this single cycle; next state IDLE.
- cell_en=0 in every state other than P1/P2, so the cell holds its products. cell_src* hold their last value when cell_en=0.
- Latency with CELL_LATENCY=1: start sampled at edge T; done high in cycle T+5; busy high cycles T+1..T+5. Each extra CELL_LATENCY unit adds 2 cycles.
- flush:
  - In any non-IDLE state, flush forces IDLE next cycle; done is not asserted and result is unchanged.
  - flush in OUT wins over done: done=0 and result is not updated.
  - flush and start together in IDLE: flush wins, start is dropped.
- Async reset mid-operation: immediate return to reset values. The first start after deassertion behaves normally.
- Back-to-back: start may be asserted in the cycle after done (state is IDLE then). Minimum issue interval is 6 cycles at CELL_LATENCY=1.

Test Plan:
- MUL: src1=3, src2=5 -> done at T+5, result=0x0000000F, exactly two cell_en pulses (T+1, T+2).
- MULXUU: 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. Same operands with MUL -> 0x00000001.
- MULXSS and MULXSU with src1=src2=0xFFFFFFFF -> 0x00000000 and 0xFFFFFFFF respectively.
- 0x00010000 x 0x00010000: MUL -> 0x00000000, MULXUU -> 0x00000001. Run with CELL_LATENCY=1 and 2; done at T+5 and T+7.
- start held high while busy, then flush in ACC -> no second capture, no done, result keeps its previous value, busy=0 next cycle.
- reset_n low during P2 -> busy/done/cell_en drop asynchronously. Next MULXUU 2x3 -> result=0x00000000; MUL 2x3 -> 0x00000006.
